// File: rtl/fifo_pack.sv
// fifo_pack: packs half-word writes into full-width circular-queue entries.
// Optional flush input enabled by FIFO_PACK_FLUSH_EN.
module fifo_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    rd,
`ifdef FIFO_PACK_FLUSH_EN
    input  logic                    flush,
`endif
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    empty,
    output logic                    full,
    output logic                    upper
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    upper_q, upper_d;
    logic                    empty_q, empty_d;
    logic                    full_q, full_d;
    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                    flush_in;
    logic                    up_wr;
    logic                    commit_req;
    logic                    commit_ok;
    logic                    rd_ok;
    logic [2*DATA_WIDTH-1:0] commit_data;
    logic [ADDR_WIDTH-1:0]   wr_ptr_inc;
    logic [ADDR_WIDTH-1:0]   rd_ptr_inc;

`ifdef FIFO_PACK_FLUSH_EN
    assign flush_in = flush;
`else
    assign flush_in = 1'b0;
`endif

    always_comb begin
        wr_ptr_inc  = wr_ptr_q + 1'b1;
        rd_ptr_inc  = rd_ptr_q + 1'b1;
        // flush outranks wr, so a write in a flush cycle is dropped
        up_wr       = wr & upper_q & ~flush_in;
        commit_req  = ~upper_q & (flush_in | wr);
        commit_ok   = commit_req & (~full_q | rd);
        rd_ok       = rd & ~empty_q;
        commit_data = flush_in ? {hold_q, {DATA_WIDTH{1'b0}}}
                               : {hold_q, w_data};

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        upper_d  = upper_q;
        empty_d  = empty_q;
        full_d   = full_q;

        if (up_wr) begin
            hold_d  = w_data;
            upper_d = 1'b0;
        end
        if (commit_ok) begin
            wr_ptr_d = wr_ptr_inc;
            upper_d  = 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_inc;
        end

        if (commit_ok && !rd_ok) begin
            empty_d = 1'b0;
            full_d  = (wr_ptr_inc == rd_ptr_q);
        end else if (rd_ok && !commit_ok) begin
            full_d  = 1'b0;
            empty_d = (rd_ptr_inc == wr_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
            upper_q  <= 1'b1;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
            upper_q  <= upper_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // storage carries no reset; only committed slots are ever read
    always_ff @(posedge clk) begin
        if (commit_ok) begin
            mem_q[wr_ptr_q] <= commit_data;
        end
    end

    assign r_data = mem_q[rd_ptr_q];
    assign empty  = empty_q;
    assign full   = full_q;
    assign upper  = upper_q;

endmodule

// File: tb/tb_fifo_pack.sv
// tb_fifo_pack: scoreboard bench for fifo_pack (DATA_WIDTH=8, ADDR_WIDTH=2).
// Covers FIFO_PACK_FLUSH_EN when that macro is defined.
module tb_fifo_pack;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef FIFO_PACK_FLUSH_EN
    localparam bit FLEN = 1'b1;
`else
    localparam bit FLEN = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          wr     = 1'b0;
    logic          rd     = 1'b0;
    logic          flush  = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic [2*DW-1:0] r_data;
    logic          empty;
    logic          full;
    logic          upper;

    int errors = 0;
    int checks = 0;

    logic [2*DW-1:0] sb [$];
    int              cnt     = 0;
    bit              m_upper = 1'b1;
    logic [DW-1:0]   m_hold  = '0;

    fifo_pack #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
`ifdef FIFO_PACK_FLUSH_EN
        .flush  (flush),
`endif
        .r_data (r_data),
        .empty  (empty),
        .full   (full),
        .upper  (upper)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        cnt     = 0;
        m_upper = 1'b1;
        m_hold  = '0;
    endtask

    task automatic flags(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, ".full"},  32'(full),  32'(cnt == DEPTH));
        chk({tag, ".upper"}, 32'(upper), 32'(m_upper));
        if (cnt > 0) chk({tag, ".head"}, 32'(r_data), 32'(sb[0]));
    endtask

    // drive one cycle (called #1 after an edge), model it, check after edge
    task automatic cyc(input bit w, input logic [DW-1:0] d,
                       input bit r, input bit f, input string tag);
        bit              rd_ok;
        bit              com;
        bit              fl;
        logic [2*DW-1:0] cd;
        logic [2*DW-1:0] exp;
        wr     = w;
        w_data = d;
        rd     = r;
        flush  = f;
        fl     = f && FLEN;
        rd_ok  = r && (cnt > 0);
        com    = !m_upper && (fl || w) && ((cnt < DEPTH) || r);
        cd     = fl ? {m_hold, 8'h00} : {m_hold, d};
        if (rd_ok) begin
            exp = sb.pop_front();
            chk({tag, ".pop"}, 32'(r_data), 32'(exp));
        end
        if (com) sb.push_back(cd);
        cnt = cnt + int'(com) - int'(rd_ok);
        if (!fl && w && m_upper) begin
            m_hold  = d;
            m_upper = 1'b0;
        end else if (com) begin
            m_upper = 1'b1;
        end
        @(posedge clk);
        #1;
        wr    = 1'b0;
        rd    = 1'b0;
        flush = 1'b0;
        flags(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (cnt > 0) cyc(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        flags("rst");
        reset = 1'b1;

        cyc(1'b1, 8'h01, 1'b0, 1'b0, "pre");
        cyc(1'b1, 8'h02, 1'b0, 1'b0, "pre");
        cyc(1'b1, 8'h03, 1'b0, 1'b0, "pre");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        flags("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "rd_after_rst");

        cyc(1'b1, 8'hAB, 1'b0, 1'b0, "wr_ab");
        cyc(1'b1, 8'hCD, 1'b0, 1'b0, "wr_cd");
        chk("abcd", 32'(r_data), 32'h0000ABCD);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "pop_abcd");

        cyc(1'b1, 8'h11, 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'h22, 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'h33, 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'h44, 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'h55, 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'h66, 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'h77, 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'h88, 1'b0, 1'b0, "fill");
        chk("full4", 32'(full), 32'd1);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, "up_on_full");
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, "lo_blocked");
        chk("blocked_upper", 32'(upper), 32'd0);

        chk("head_1122", 32'(r_data), 32'h00001122);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0, "wr_rd_full");
        chk("still_full", 32'(full), 32'd1);
        chk("head_3344", 32'(r_data), 32'h00003344);

        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "wrap_rd");
        chk("empty_after", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "rd_empty");

        for (int i = 0; i < 400; i++) begin
            bit w;
            bit r;
            bit f;
            w = ($urandom_range(0, 3) != 0);
            r = (i % 64 < 32) ? ($urandom_range(0, 3) == 0)
                              : ($urandom_range(0, 3) != 0);
            f = FLEN ? ($urandom_range(0, 7) == 0) : 1'b0;
            cyc(w, 8'($urandom), r, f, "rand");
        end

        drain();
        if (!m_upper) cyc(1'b1, 8'h00, 1'b0, 1'b0, "finish_pair");
        drain();

`ifdef FIFO_PACK_FLUSH_EN
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, "fl_up");
        cyc(1'b1, 8'h77, 1'b0, 1'b1, "fl_go");
        chk("fl_data", 32'(r_data), 32'h00005A00);
        chk("fl_upper", 32'(upper), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "fl_noop");
        cyc(1'b1, 8'h66, 1'b0, 1'b1, "fl_wr_drop");
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_pack.md
# fifo_pack

Width-converting FIFO that packs pairs of narrow write half-words into full-width entries and pops whole entries on the read side. It sits between a narrow producer (DATA_WIDTH bits per beat) and a wide consumer (2*DATA_WIDTH bits per pop). It contains the pack holding register, the register-file storage and the circular-queue pointer control. A half-word pair becomes visible to the reader only once both halves are written.

## Interface
- DATA_WIDTH, default 8: width of one write half-word; read width is 2*DATA_WIDTH.
- ADDR_WIDTH, default 4: storage depth is 2**ADDR_WIDTH full-width entries.

- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserts immediately when low, releases synchronously to clk in the system).
- wr  input  1  write request for one half-word.
- w_data  input  DATA_WIDTH  half-word to write.
- rd  input  1  read (pop) request for one full entry.
- r_data  output  2*DATA_WIDTH  entry at head of queue: {upper half, lower half}.
- empty  output  1  no complete entry stored.
- full  output  1  all 2**ADDR_WIDTH entries occupied.
- upper  output  1  1 = next accepted write is an upper half; 0 = an upper half is held and the next write completes the pair.
- flush  input  1  present only with FIFO_PACK_FLUSH_EN (see Configuration).

## Operation
- State: wr_ptr, rd_ptr (ADDR_WIDTH, wrap modulo 2**ADDR_WIDTH), hold (DATA_WIDTH), upper, empty, full. Storage is not reset.
- Upper-half write (wr=1, upper=1): always accepted, including when full; w_data -> hold; upper -> 0; pointers, empty, full unchanged.
- Lower-half write (wr=1, upper=0): "commit". Accepted when ~full, or when full and rd=1 in the same cycle. On accept: mem[wr_ptr] <= {hold, w_data}; wr_ptr += 1; upper -> 1; empty -> 0. When rejected (full, rd=0): no state change; hold and upper=0 retained; producer must retry.
- Read (rd=1): accepted when ~empty; rd_ptr += 1; full -> 0. Ignored when empty, even if a commit occurs the same cycle.
- Flags after an accepted operation:
  - Commit without read: full = (wr_ptr+1 == rd_ptr).
  - Read without commit: empty = (rd_ptr+1 == wr_ptr).
  - Commit and read together: empty and full unchanged.
- r_data = mem[rd_ptr], combinational read. It is valid whenever empty=0, and it is undefined when empty=1.
- Simultaneous read and commit on a full FIFO with wr_ptr == rd_ptr: r_data is the pre-edge (old) entry; the new entry is written into the freed slot.
- A held upper half is never visible to the reader and does not count toward full or empty.

## Timing
- Reset values (reset low): wr_ptr=0, rd_ptr=0, hold=0, upper=1, empty=1, full=0; r_data undefined.
- Reset mid-operation discards any held half-word and all stored entries; flags return to reset values asynchronously.
- Write-to-read latency: empty deasserts the cycle after the committing edge, and r_data shows the entry in that same cycle.
- Read: r_data advances to the next entry in the cycle after the popping edge.
- All flag outputs are registered; there are no combinational paths from rd/wr to empty/full/upper.

## Configuration
- FIFO_PACK_FLUSH_EN defined: adds the flush input.
  - flush=1 with upper=0 and (~full or rd=1) commits {hold, DATA_WIDTH'(0)}, advances wr_ptr and sets upper=1, following the commit flag rules.
  - flush has priority over wr in the same cycle; that wr is ignored.
  - flush with upper=1 is a no-op.
- FIFO_PACK_FLUSH_EN undefined: no flush port; a partial pair stays held until its lower half arrives.

## Test plan
(DATA_WIDTH=8, ADDR_WIDTH=2)
- Reset low mid-stream, then high -> empty=1, full=0, upper=1; a following rd changes nothing.
- Write 0xAB, then 0xCD -> after first edge upper=0, empty=1; after second edge empty=0 and r_data=0xABCD.
- Commit 4 pairs (0x1122, 0x3344, 0x5566, 0x7788) -> full=1 after the 4th. A 5th upper write is accepted (upper=0), but its lower write is held off while rd=0.
- From full with an upper half held: lower write plus rd in the same cycle -> r_data=0x1122 before the edge, full stays 1, and the next r_data=0x3344.
- Read 4 entries with wrap-around after 6 total commits -> data emerges in order; empty=1 after the last pop; rd on empty is ignored.
- FIFO_PACK_FLUSH_EN: write 0x5A, then flush -> next r_data=0x5A00 and upper=1; flush with upper=1 -> no change.
